rr_arbiter_burst: RTL and testbench

Parametrised round-robin arbiter for N requesters with registered one-hot grants, per-grant burst tenure and a configurable burst cap. It is the next-generation replacement for the fixed 4-way, single-cycle-tenure arbiter and sits in front of shared buses, memory ports and DMA channels. A granted requester keeps ownership while it holds its request, up to MAX_BURST cycles. Arbitration then passes to the next requester in rotation with no idle cycle.

---
 rtl/rr_arbiter_burst.sv | 123 ++++++++++++
 tb/tb_rr_arbiter_burst.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_burst.sv
// Round-robin arbiter for N requesters with burst tenure capped at MAX_BURST; optional RR_ARB_LOCK_EN adds a tenure lock.
// Request-to-grant is one cycle when idle; no backpressure: a requester holds req until served and drops it to release.
module rr_arbiter_burst #(
    parameter int N         = 4,
    parameter int MAX_BURST = 4,
    parameter int IDXW      = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
`ifdef RR_ARB_LOCK_EN
    input  logic            lock,
`endif
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [IDXW-1:0] grant_idx,
    output logic            burst_last
);
    localparam int              CNTW     = $clog2(MAX_BURST + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAX_BURST - 1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t          r_state, w_state_nxt;
    logic [IDXW-1:0] r_owner, w_owner_nxt;
    logic [IDXW-1:0] r_ptr, w_ptr_nxt;
    logic [CNTW-1:0] r_cnt, w_cnt_nxt;
    logic [IDXW-1:0] w_start, w_win;
    logic            w_busy, w_found, w_cnt_lt, w_hold;

    // Wrap explicitly at N so non-power-of-two sizes never select a phantom index.
    function automatic logic [IDXW-1:0] inc_mod(input logic [IDXW-1:0] v);
        return (v == IDX_LAST) ? '0 : v + IDXW'(1);
    endfunction

    assign w_busy   = (r_state == S_GRANT);
    assign w_start  = w_busy ? inc_mod(r_owner) : r_ptr;
    assign w_cnt_lt = (r_cnt < CNT_LAST);

`ifdef RR_ARB_LOCK_EN
    assign w_hold = req[r_owner] && (w_cnt_lt || lock);
`else
    assign w_hold = req[r_owner] && w_cnt_lt;
`endif

    // Search start..start+N-1; when busy the owner sits at the end so it is checked last.
    always_comb begin
        logic [IDXW:0] w_sum;
        w_sum   = '0;
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, w_start} + (IDXW+1)'(i);
            if (w_sum >= (IDXW+1)'(N)) begin
                w_sum = w_sum - (IDXW+1)'(N);
            end
            if (!w_found && req[w_sum[IDXW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[IDXW-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_GRANT;
                    w_owner_nxt = w_win;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = inc_mod(w_win);
                end
            end
            S_GRANT: begin
                if (w_hold) begin
                    w_cnt_nxt = w_cnt_lt ? r_cnt + CNTW'(1) : r_cnt;
                end else if (w_found) begin
                    w_owner_nxt = w_win;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = inc_mod(w_win);
                end else begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_cnt   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        grant = '0;
        if (w_busy) begin
            grant[r_owner] = 1'b1;
        end
    end

    assign grant_valid = w_busy;
    assign grant_idx   = w_busy ? r_owner : '0;
    assign burst_last  = w_busy && (r_cnt == CNT_LAST);

endmodule

// File: tb/tb_rr_arbiter_burst.sv
// Directed bench for rr_arbiter_burst (N=4, MAX_BURST=4, lock feature not built).
module tb_rr_arbiter_burst;
    localparam int N  = 4;
    localparam int MB = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_idx;
    logic         burst_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_arbiter_burst #(.N(N), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .grant      (grant),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx),
        .burst_last (burst_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] idx, input logic bl);
        chk($sformatf("%s.grant", tag),       32'(grant),       32'(g));
        chk($sformatf("%s.grant_valid", tag), 32'(grant_valid), 32'(|g));
        chk($sformatf("%s.grant_idx", tag),   32'(grant_idx),   32'(idx));
        chk($sformatf("%s.burst_last", tag),  32'(burst_last),  32'(bl));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] g;
        int         o;

        // Reset state and reset mid-tenure
        #2;
        chk_out("reset", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        req = 4'b0010;
        step();
        chk_out("first_grant", 4'b0010, 2'd1, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 4'b0000, 2'd0, 1'b0);
        req = 4'b1000;
        #2;
        rst = 1'b0;
        step();
        chk_out("post_rst", 4'b1000, 2'd3, 1'b0);
        req = 4'b0000;
        step();
        chk_out("to_idle", 4'b0000, 2'd0, 1'b0);

        // Sole requester: continuous grant, burst_last every 4th cycle
        req = 4'b0100;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk_out($sformatf("single_c%0d", i), 4'b0100, 2'd2, (i % 4) == 0);
        end
        req = 4'b0000;
        step();
        chk_out("single_idle", 4'b0000, 2'd0, 1'b0);

        // All requesting from reset: 4-cycle tenures in rotation
        req = 4'b1111;
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            step();
            o = ((i - 1) / 4) % 4;
            g = 4'b0001 << o;
            chk_out($sformatf("all_c%0d", i), g, 2'(o), (i % 4) == 0);
        end
        req = 4'b0000;
        step();

        // Early release by owner 0 hands over without a bubble
        req = 4'b0011;
        do_reset();
        step();
        chk_out("early_c1", 4'b0001, 2'd0, 1'b0);
        step();
        chk_out("early_c2", 4'b0001, 2'd0, 1'b0);
        req = 4'b0010;
        step();
        chk_out("early_switch", 4'b0010, 2'd1, 1'b0);
        req = 4'b0011;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk_out($sformatf("early_own1_c%0d", i), 4'b0010, 2'd1, i == 3);
        end
        step();
        chk_out("early_back0", 4'b0001, 2'd0, 1'b0);
        req = 4'b0000;
        step();

        // Wrap from owner 3 to 0, then alternate fairly
        req = 4'b1000;
        do_reset();
        step();
        chk_out("wrap_own3", 4'b1000, 2'd3, 1'b0);
        req = 4'b1001;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk_out($sformatf("wrap_hold3_c%0d", i), 4'b1000, 2'd3, i == 3);
        end
        step();
        chk_out("wrap_to0", 4'b0001, 2'd0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk_out($sformatf("wrap_hold0_c%0d", i), 4'b0001, 2'd0, i == 3);
        end
        step();
        chk_out("fair_to3", 4'b1000, 2'd3, 1'b0);
        for (int i = 1; i <= 3; i++) step();
        step();
        chk_out("fair_to0", 4'b0001, 2'd0, 1'b0);
        req = 4'b0000;
        step();
        chk_out("final_idle", 4'b0000, 2'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
